// File: rtl/tiny_dnn_pkg.sv
// Shared types and default widths for the ping-pong batch controller.
//   src_st_e : stream-in FSM states
//   cmp_st_e : compute handshake FSM states
//   drn_st_e : stream-out (drain) FSM states
package tiny_dnn_pkg;

  localparam int TD_DATA_W = 32;
  localparam int TD_ADDR_W = 12;
  localparam int TD_CNT_W  = 12;

  typedef enum logic {SI_IDLE, SI_LOAD} src_st_e;
  typedef enum logic {CI_IDLE, CI_BUSY} cmp_st_e;
  typedef enum logic {DI_IDLE, DI_READ} drn_st_e;

endpackage

// File: rtl/tiny_dnn_pp_batch_ctrl_skid.sv
// tiny_dnn_skid: 2-entry valid/ready buffer that absorbs the one-cycle
// dst buffer read latency. The producer must not push while count==2
// unless a pop happens in the same cycle.
//   clk, reset        : clock, async active-high reset
//   flush             : synchronous drop of all entries
//   in_valid/in_data  : push side (no ready; producer tracks count)
//   out_valid/out_data/out_ready : pop side
//   count             : current occupancy 0..2
module tiny_dnn_skid #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   count
);

  logic [W-1:0] d0, d1;
  logic [1:0]   cnt;
  logic         pop;

  assign out_valid = (cnt != 2'd0);
  assign out_data  = d0;
  assign count     = cnt;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      d0  <= '0;
      d1  <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case ({in_valid, pop})
        2'b10: begin
          if (cnt == 2'd0) d0 <= in_data;
          else             d1 <= in_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          d0  <= d1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          // d0 leaves; the new word goes behind whatever remains
          if (cnt == 2'd1) d0 <= in_data;
          else begin
            d0 <= d1;
            d1 <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tiny_dnn_pp_batch_ctrl.sv
// tiny_dnn_pp_batch_ctrl: ping-pong batch controller. Overlaps stream-in of
// sample n+1 (bank wb), compute of sample n (bank cb) and stream-out of
// sample n-1 (bank rb) using src_full/dst_full ownership flags per bank.
//   run                       : level enable; low returns everything to idle
//   ss, ds                    : source / destination words per sample minus one
//   src_valid/data/last/ready : input stream
//   src_we/bank/a/wd          : src buffer write port
//   s_init, c_bank, s_fin     : compute handshake and bank owned by compute
//   dst_re/bank/a, dst_rd     : dst buffer read port (1-cycle latency)
//   dst_valid/data/last/ready : output stream
//   err_last                  : sticky, src_last not aligned to word ss
// Optional macro TINY_DNN_PERF_EN adds saturating perf counters
// perf_src_stall, perf_dst_stall and perf_samples.
module tiny_dnn_pp_batch_ctrl
  import tiny_dnn_pkg::*;
#(
  parameter int DATA_W = TD_DATA_W,
  parameter int ADDR_W = TD_ADDR_W,
  parameter int CNT_W  = TD_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [CNT_W-1:0]  ss,
  input  logic [CNT_W-1:0]  ds,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  input  logic              src_last,
  output logic              src_ready,
  output logic              src_we,
  output logic              src_bank,
  output logic [ADDR_W-1:0] src_a,
  output logic [DATA_W-1:0] src_wd,
  output logic              s_init,
  output logic              c_bank,
  input  logic              s_fin,
  output logic              dst_re,
  output logic              dst_bank,
  output logic [ADDR_W-1:0] dst_a,
  input  logic [DATA_W-1:0] dst_rd,
  output logic              dst_valid,
  output logic [DATA_W-1:0] dst_data,
  output logic              dst_last,
  input  logic              dst_ready,
`ifdef TINY_DNN_PERF_EN
  output logic [31:0]       perf_src_stall,
  output logic [31:0]       perf_dst_stall,
  output logic [31:0]       perf_samples,
`endif
  output logic              err_last
);

  src_st_e src_st, src_nxt;
  cmp_st_e cmp_st, cmp_nxt;
  drn_st_e drn_st, drn_nxt;

  logic [1:0]       src_full, dst_full, src_full_n, dst_full_n;
  logic             wb, cb, rb;
  logic [CNT_W-1:0] src_cnt, rd_cnt;
  logic             rd_done, rd_pend, rd_pend_last;
  logic             at_end, src_close, err_evt, fin, drn_done, pop, room;
  logic [1:0]       skid_cnt;
  logic [2:0]       occ;

  // ---- stream-in ----
  assign src_ready = (src_st == SI_LOAD);
  assign src_we    = src_valid & src_ready;
  assign src_bank  = wb;
  assign src_a     = ADDR_W'(src_cnt);
  assign src_wd    = src_we ? src_data : '0;
  assign at_end    = (src_cnt == ss);
  // an early last closes the bank at that beat
  assign src_close = src_we & (at_end | src_last);
  assign err_evt   = src_we & (at_end ^ src_last);

  always_comb begin
    src_nxt = src_st;
    case (src_st)
      SI_IDLE: if (!src_full[wb]) src_nxt = SI_LOAD;
      SI_LOAD: if (src_close)     src_nxt = SI_IDLE;
      default: src_nxt = SI_IDLE;
    endcase
    if (!run) src_nxt = SI_IDLE;
  end

  // ---- compute handshake ----
  assign s_init = run & (cmp_st == CI_IDLE) & src_full[cb] & ~dst_full[cb];
  assign c_bank = cb;
  assign fin    = run & (cmp_st == CI_BUSY) & s_fin;

  always_comb begin
    cmp_nxt = cmp_st;
    case (cmp_st)
      CI_IDLE: if (s_init) cmp_nxt = CI_BUSY;
      CI_BUSY: if (fin)    cmp_nxt = CI_IDLE;
      default: cmp_nxt = CI_IDLE;
    endcase
    if (!run) cmp_nxt = CI_IDLE;
  end

  // ---- drain ----
  // occupancy after this cycle (buffered + in flight - popped) must leave
  // space for the read issued now
  assign pop      = dst_valid & dst_ready;
  assign occ      = {1'b0, skid_cnt} + {2'b0, rd_pend} - {2'b0, pop};
  assign room     = (occ < 3'd2);
  assign dst_re   = run & (drn_st == DI_READ) & ~rd_done & room;
  assign dst_bank = rb;
  assign dst_a    = ADDR_W'(rd_cnt);
  assign drn_done = (drn_st == DI_READ) & pop & dst_last;

  always_comb begin
    drn_nxt = drn_st;
    case (drn_st)
      DI_IDLE: if (dst_full[rb]) drn_nxt = DI_READ;
      DI_READ: if (drn_done)     drn_nxt = DI_IDLE;
      default: drn_nxt = DI_IDLE;
    endcase
    if (!run) drn_nxt = DI_IDLE;
  end

  tiny_dnn_skid #(.W(DATA_W + 1)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (~run),
    .in_valid  (rd_pend),
    .in_data   ({rd_pend_last, dst_rd}),
    .out_valid (dst_valid),
    .out_data  ({dst_last, dst_data}),
    .out_ready (dst_ready),
    .count     (skid_cnt)
  );

  // ---- bank flags: sets applied after clears so a set wins ----
  always_comb begin
    src_full_n = src_full;
    dst_full_n = dst_full;
    if (fin)       src_full_n[cb] = 1'b0;
    if (src_close) src_full_n[wb] = 1'b1;
    if (drn_done)  dst_full_n[rb] = 1'b0;
    if (fin)       dst_full_n[cb] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_st <= SI_IDLE;
      cmp_st <= CI_IDLE;
      drn_st <= DI_IDLE;
    end else begin
      src_st <= src_nxt;
      cmp_st <= cmp_nxt;
      drn_st <= drn_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_full     <= '0;
      dst_full     <= '0;
      wb           <= 1'b0;
      cb           <= 1'b0;
      rb           <= 1'b0;
      src_cnt      <= '0;
      rd_cnt       <= '0;
      rd_done      <= 1'b0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
    end else if (!run) begin
      src_full     <= '0;
      dst_full     <= '0;
      wb           <= 1'b0;
      cb           <= 1'b0;
      rb           <= 1'b0;
      src_cnt      <= '0;
      rd_cnt       <= '0;
      rd_done      <= 1'b0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
    end else begin
      src_full     <= src_full_n;
      dst_full     <= dst_full_n;
      rd_pend      <= dst_re;
      rd_pend_last <= dst_re & (rd_cnt == ds);
      if (src_close) begin
        wb      <= ~wb;
        src_cnt <= '0;
      end else if (src_we) begin
        src_cnt <= src_cnt + 1'b1;
      end
      if (fin) cb <= ~cb;
      if (drn_done) begin
        rb      <= ~rb;
        rd_cnt  <= '0;
        rd_done <= 1'b0;
      end else if (dst_re) begin
        if (rd_cnt == ds) rd_done <= 1'b1;
        else              rd_cnt  <= rd_cnt + 1'b1;
      end
    end
  end

  // sticky across run low; only reset clears it
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              err_last <= 1'b0;
    else if (run & err_evt) err_last <= 1'b1;
  end

`ifdef TINY_DNN_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_src_stall <= '0;
      perf_dst_stall <= '0;
      perf_samples   <= '0;
    end else if (!run) begin
      perf_src_stall <= '0;
      perf_dst_stall <= '0;
      perf_samples   <= '0;
    end else begin
      if (src_valid & ~src_ready & (perf_src_stall != '1)) perf_src_stall <= perf_src_stall + 1'b1;
      if (dst_valid & ~dst_ready & (perf_dst_stall != '1)) perf_dst_stall <= perf_dst_stall + 1'b1;
      if (fin & (perf_samples != '1))                      perf_samples   <= perf_samples + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tiny_dnn_pp_batch_ctrl.sv
module tb_tiny_dnn_pp_batch_ctrl;

  localparam logic [31:0] MASK = 32'hFFFF_0000;

  logic        clk, rst, run;
  logic [11:0] ss, ds;
  logic        src_valid, src_last, src_ready, src_we, src_bank;
  logic [31:0] src_data, src_wd, dst_rd, dst_data;
  logic [11:0] src_a, dst_a;
  logic        s_init, c_bank, s_fin, dst_re, dst_bank, dst_valid, dst_last, dst_ready, err_last;

  tiny_dnn_pp_batch_ctrl #(.DATA_W(32), .ADDR_W(12), .CNT_W(12)) dut (
    .clk(clk), .reset(rst), .run(run), .ss(ss), .ds(ds),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last), .src_ready(src_ready),
    .src_we(src_we), .src_bank(src_bank), .src_a(src_a), .src_wd(src_wd),
    .s_init(s_init), .c_bank(c_bank), .s_fin(s_fin),
    .dst_re(dst_re), .dst_bank(dst_bank), .dst_a(dst_a), .dst_rd(dst_rd),
    .dst_valid(dst_valid), .dst_data(dst_data), .dst_last(dst_last), .dst_ready(dst_ready),
    .err_last(err_last)
  );

  typedef struct packed {logic bank; logic [11:0] a; logic [31:0] d;} wr_t;

  wr_t         src_q[$];
  logic        init_q[$];
  logic [32:0] dst_q[$];
  logic [31:0] srcmem [2][16];
  logic [31:0] dstmem [2][16];
  int n_chk = 0, n_pass = 0, cyc = 0, n_init = 0, beats = 0;
  int last_we_cyc = 0, init_cyc = 0, max_wait = 0;
  int comp_lat = 3, rdy_mode = 0;
  logic exp_wb = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial forever begin @(posedge clk); cyc++; end

  // dst_ready pattern generator
  initial begin
    dst_ready = 0;
    forever begin
      @(posedge clk); #2;
      case (rdy_mode)
        0:       dst_ready = 1'b1;
        1:       dst_ready = ~dst_ready;
        default: dst_ready = 1'b0;
      endcase
    end
  end

  // dst buffer read model, 1-cycle latency
  initial begin
    logic pre, pb;
    logic [3:0] pa;
    dst_rd = '0;
    forever begin
      @(negedge clk);
      pre = dst_re; pb = dst_bank; pa = dst_a[3:0];
      @(posedge clk); #1;
      if (pre) dst_rd = dstmem[pb][pa];
    end
  end

  // compute model: after comp_lat cycles copy src bank ^ MASK into dst bank, pulse s_fin
  initial begin
    bit cbusy;
    int ctimer;
    logic cbank;
    cbusy = 0; ctimer = 0; cbank = 0; s_fin = 0;
    forever begin
      @(negedge clk);
      s_fin = 0;
      if (rst || !run) cbusy = 0;
      else if (cbusy) begin
        if (ctimer == 0) begin
          for (int j = 0; j < 16; j++) dstmem[cbank][j] = srcmem[cbank][j] ^ MASK;
          s_fin = 1; cbusy = 0;
        end else ctimer--;
      end else if (s_init) begin
        cbusy = 1; cbank = c_bank; ctimer = comp_lat;
      end
    end
  end

  // monitor / scoreboard
  initial begin
    logic armed;
    logic [32:0] held;
    int infl;
    armed = 0; held = '0; infl = 0;
    forever begin
      @(negedge clk);
      if (rst || !run) begin
        armed = 0; infl = 0;
      end else begin
        if (src_we) begin
          srcmem[src_bank][src_a[3:0]] = src_wd;
          last_we_cyc = cyc;
          if (src_q.size() == 0) chk("src_unexpected", src_q.size(), 1);
          else chk("src_write", {src_bank, src_a, src_wd}, src_q.pop_front());
        end
        if (s_init) begin
          n_init++; init_cyc = cyc;
          if (init_q.size() == 0) chk("init_unexpected", init_q.size(), 1);
          else chk("c_bank", c_bank, init_q.pop_front());
        end
        if (armed) chk("dst_hold", {dst_valid, dst_last, dst_data}, {1'b1, held});
        infl = infl + int'(dst_re) - int'(dst_valid && dst_ready);
        if (dst_re) chk("inflight_le2", infl <= 2, 1);
        if (dst_valid && dst_ready) begin
          beats++;
          if (dst_q.size() == 0) chk("dst_unexpected", dst_q.size(), 1);
          else chk("dst_beat", {dst_last, dst_data}, dst_q.pop_front());
        end
        armed = dst_valid && !dst_ready;
        held  = {dst_last, dst_data};
      end
    end
  end

  task automatic send_sample(input int n, input int lp, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      src_valid = 1; src_data = base + 32'(i); src_last = (i == lp);
      src_q.push_back(wr_t'{exp_wb, 12'(i), base + 32'(i)});
      @(negedge clk);
      while (!src_ready && t < 500) begin t++; @(negedge clk); end
      if (t > max_wait) max_wait = t;
      if (t >= 500) begin
        chk("src_accept_timeout", t, 0);
        src_valid = 0; src_last = 0;
        return;
      end
      @(posedge clk); #1;
    end
    src_valid = 0; src_last = 0;
    if (lp >= 0) begin
      for (int j = 0; j <= int'(ds); j++)
        dst_q.push_back({(j == int'(ds)), (base + 32'(j)) ^ MASK});
      init_q.push_back(exp_wb);
      exp_wb = ~exp_wb;
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((src_q.size() != 0 || init_q.size() != 0 || dst_q.size() != 0) && t < 3000) begin
      @(negedge clk); #1; t++;
    end
    chk("idle_timeout", t < 3000, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic restart();
    @(posedge clk); #1;
    run = 0;
    repeat (2) @(posedge clk);
    #1;
    run = 1; exp_wb = 0;
  endtask

  initial begin
    int b0, n0, t;
    rst = 1; run = 0; src_valid = 0; src_data = 0; src_last = 0; ss = 12'd3; ds = 12'd1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {src_ready, src_we, s_init, c_bank, dst_re, dst_valid, err_last}, 7'b0);
    rst = 0; run = 1;

    // T1: single sample ss=3 ds=1
    send_sample(4, 3, 32'h0000_1000);
    wait_idle();
    chk("t1_init_latency", init_cyc - last_we_cyc, 1);
    chk("t1_final", {dst_valid, dst_re, s_init, err_last}, 4'b0);

    // T2: three back-to-back samples with long compute
    restart();
    ss = 12'd7; ds = 12'd7; comp_lat = 20; max_wait = 0; n0 = n_init;
    send_sample(8, 7, 32'h0000_2000);
    send_sample(8, 7, 32'h0000_2100);
    send_sample(8, 7, 32'h0000_2200);
    wait_idle();
    chk("t2_init_count", n_init - n0, 3);
    chk("t2_src_stall_le20", max_wait <= 20, 1);

    // T3: toggling dst_ready, ds=5
    restart();
    ss = 12'd5; ds = 12'd5; comp_lat = 2; rdy_mode = 1; b0 = beats;
    send_sample(6, 5, 32'h0000_3000);
    wait_idle();
    chk("t3_beats", beats - b0, 6);

    // T4: early last then correct sample, err_last sticky
    restart();
    ss = 12'd3; ds = 12'd1; rdy_mode = 0;
    chk("t4_err_clear", err_last, 0);
    send_sample(3, 2, 32'h0000_4000);
    wait_idle();
    chk("t4_err_set", err_last, 1);
    send_sample(4, 3, 32'h0000_4100);
    wait_idle();
    chk("t4_err_sticky", err_last, 1);

    // T5: run dropped mid-drain
    restart();
    chk("t5_err_held", err_last, 1);
    ss = 12'd5; ds = 12'd5; b0 = beats;
    send_sample(6, 5, 32'h0000_5000);
    t = 0;
    while (beats < b0 + 3 && t < 2000) begin @(negedge clk); #1; t++; end
    chk("t5_wait_beat3", t < 2000, 1);
    @(posedge clk); #1;
    run = 0; rdy_mode = 2;
    @(posedge clk); #1;
    chk("t5_abort", {dst_valid, dst_re, src_ready, s_init}, 4'b0);
    dst_q.delete();
    run = 1; exp_wb = 0; rdy_mode = 0;
    send_sample(6, 5, 32'h0000_5100);
    wait_idle();

    // T6: async reset mid-load, then cold start
    ss = 12'd3; ds = 12'd1;
    send_sample(2, -1, 32'h0000_6000);
    src_valid = 1; src_data = 32'h0000_6002;
    #1 chk("t6_pre_we", src_we, 1);
    #1 rst = 1;
    #1 chk("t6_async", {src_ready, src_we, s_init}, 3'b0);
    src_valid = 0;
    src_q.delete(); init_q.delete(); dst_q.delete(); exp_wb = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("t6_post_rst", {err_last, dst_valid}, 2'b0);
    send_sample(4, 3, 32'h0000_7000);
    wait_idle();
    chk("t6_init_latency", init_cyc - last_we_cyc, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tiny_dnn_pp_batch_ctrl.md
Name: tiny_dnn_pp_batch_ctrl

Overview:
Parametrised successor of the accelerator's batch controller. It drives ping-pong (two-bank) source and destination sample buffers, so three things overlap: stream-in of sample n+1, compute of sample n, and stream-out of sample n-1. It sits between the AXI-stream-style src/dst ports and the sample controller/core array, and handles buffer addressing, bank ownership, s_init/s_fin sequencing and output backpressure.

Parameters:
DATA_W, 32, width of src_data/dst_data stream words
ADDR_W, 12, buffer word address width (per bank)
CNT_W, 12, width of ss/ds sample-length fields (words minus one)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
run  in  1  level; enables operation, low aborts and returns to idle
ss  in  CNT_W  source words per sample minus one
ds  in  CNT_W  destination words per sample minus one
src_valid  in  1  input stream valid
src_data  in  DATA_W  input stream word (forwarded to buffer)
src_last  in  1  input stream last-of-sample marker
src_ready  out  1  input stream ready
src_we  out  1  src buffer write enable
src_bank  out  1  src buffer bank being written
src_a  out  ADDR_W  src buffer write address
src_wd  out  DATA_W  src buffer write data
s_init  out  1  one-cycle pulse: start compute of one sample
c_bank  out  1  bank pair (src read / dst write) owned by compute
s_fin  in  1  one-cycle pulse from sample control: compute done
dst_re  out  1  dst buffer read enable (data returns next cycle)
dst_bank  out  1  dst buffer bank being read
dst_a  out  ADDR_W  dst buffer read address
dst_rd  in  DATA_W  dst buffer read data, 1-cycle latency
dst_valid  out  1  output stream valid
dst_data  out  DATA_W  output stream word
dst_last  out  1  output stream last-of-sample
dst_ready  in  1  output stream ready
err_last  out  1  sticky: src_last arrived before or after word ss

Behaviour:
- Reset (async, active-high): all outputs 0, src_full[1:0]=0, dst_full[1:0]=0, all bank pointers 0, every FSM idle.
- run low, synchronous: same state as reset on the next edge, except err_last is held. An in-flight stream is abandoned; dst_valid drops immediately.
- Src FSM, states SI_IDLE -> SI_LOAD -> SI_IDLE:
  - Bank select: leaves SI_IDLE when run=1 and src_full[wb]=0.
  - src_ready=1 only in SI_LOAD.
  - Each accepted beat (valid&ready): src_we=1 in the same cycle, src_a=count, src_wd=src_data, count++.
  - At count==ss: the beat sets src_full[wb], toggles wb and returns to SI_IDLE. src_last is expected on this beat.
  - If src_last is absent on the count==ss beat, or arrives early, err_last is set and the bank is still closed at the beat that ends the sample (early last closes the bank early).
- Compute FSM, states CI_IDLE -> CI_BUSY:
  - s_init pulses when in CI_IDLE with src_full[cb]=1 and dst_full[cb]=0. c_bank=cb is held through CI_BUSY.
  - On s_fin: clear src_full[cb], set dst_full[cb], toggle cb, return to CI_IDLE. s_init may pulse again on the following cycle.
  - s_fin in CI_IDLE is ignored.
- Drain FSM, states DI_IDLE -> DI_READ -> DI_IDLE:
  - Starts when dst_full[rb]=1.
  - Issues dst_re with dst_a=0..ds while the skid buffer has room, one read per cycle.
  - Data returns 1 cycle later into a 2-entry skid buffer, so sustained throughput is 1 word/cycle with dst_ready=1.
  - dst_last marks word ds.
  - After the ds beat is accepted: clear dst_full[rb], toggle rb, return to DI_IDLE.
  - dst_valid/dst_data/dst_last stay stable while dst_ready=0.
- Simultaneous events:
  - The same-cycle s_fin set and drain-complete clear target different banks by construction.
  - If they ever hit the same bank, set wins.
  - Src close and compute consume of the same bank in one cycle cannot occur because compute requires src_full already set.
- ss=0 / ds=0: single-word samples; last is asserted on the first beat.
- Address wrap: count never exceeds ss. Behaviour for ss > 2^ADDR_W-1 is undefined.

Optional Feature:
TINY_DNN_PERF_EN:
- Defined: adds outputs perf_src_stall[31:0] (cycles src_valid=1 & src_ready=0), perf_dst_stall[31:0] (dst_valid=1 & dst_ready=0) and perf_samples[31:0] (s_fin count). All are saturating, and cleared by reset or by run low.
- Undefined: these ports and their logic are absent.

Decomposition:
- Package tiny_dnn_pkg holds:
  - state enums src_st_e (SI_IDLE, SI_LOAD), cmp_st_e (CI_IDLE, CI_BUSY) and drn_st_e (DI_IDLE, DI_READ);
  - default width localparams TD_DATA_W=32, TD_ADDR_W=12, TD_CNT_W=12.
- One sub-module: tiny_dnn_skid, a parametrised 2-entry valid/ready skid buffer that absorbs the read latency.

Test Plan:
- ss=3, ds=1, no backpressure, 1 sample -> src_a 0..3 with src_bank=0; s_init 1 cycle after the 4th beat; after s_fin, dst_a 0,1 and 2 beats out with dst_last on beat 2; final flags all 0.
- 3 back-to-back samples, ss=7, compute 20 cycles -> sample 2 loads into bank 1 during compute 1; s_init count=3; c_bank sequence 0,1,0; src_ready never low for more than 20 cycles once both banks cycle.
- dst_ready toggling 1010..., ds=5 -> 6 beats in order with stable data during stalls and dst_last only on the 6th; no read overrun (at most 2 outstanding).
- src_last on beat 2 with ss=3 -> err_last=1, bank closed, s_init issued; a second sample with correct last leaves err_last=1 (sticky).
- run dropped mid-drain (beat 3 of 6) -> next cycle dst_valid=0 and src_full=dst_full=0; run re-raised -> fresh load at bank 0, src_a=0.
- reset asserted asynchronously mid-load (no clock edge) -> src_ready=0, src_we=0, s_init=0 immediately; after release, behaviour identical to a cold start.
